hb_spill_tag_gen: RTL and testbench
===================================

HB_SPILL_TAG_GEN -- requirements
Module: hb_spill_tag_gen

Interface
REQ-001 SHALL have ports: xcvrclk  in  1  XCVR RX clock, sole clock; resetn_xcvrclk  in  1  asynchronous active-low reset.
REQ-002 SHALL have input ports: hb_pkt_valid  in  1  decoded HeartBeat packet, 1-cycle pulse; hb_ewtag  in  EVENT_TAG_BITS (48)  event window tag of HB; hb_onspill  in  1  ONSPILL bit of HB; hb_null  in  1  HB carries no-data mode; pref_pkt_valid  in  1  decoded PREFETCH pulse.
REQ-003 SHALL have output ports: hb_valid  out  1  non-null on-spill HB pulse; hb_null_valid  out  1  null HB pulse; pref_valid  out  1  PREFETCH pulse; spill_hbtag  out  SPILL_TAG_BITS (20)  local spill HB counter, qualified by hb_valid; start_spill  out  1  first-HB-of-spill pulse; onspill  out  1  spill level.
REQ-004 SHALL have output ports: spill_cnt  out  32  completed spills; ewtag_skip_cnt  out  32  HB tag discontinuities; hb_offspill_cnt  out  32  HBs outside spill; hbtag_ovfl  out  1  sticky counter-saturation flag.

Function
REQ-005 SHALL implement states OFFSPILL and ONSPILL; reset state OFFSPILL.
REQ-006 SHALL, in OFFSPILL on hb_pkt_valid with hb_onspill=1: go ONSPILL, pulse start_spill, set spill_hbtag=1, pulse hb_valid (if hb_null=0), all 1 cycle after input.
REQ-007 SHALL, in ONSPILL on hb_pkt_valid with hb_onspill=1 and hb_null=0: increment spill_hbtag, pulse hb_valid, 1-cycle latency.
REQ-008 SHALL, on hb_null=1: pulse hb_null_valid only; no hb_valid, spill_hbtag unchanged (except first HB of spill, where spill_hbtag is set to 0 so next non-null HB yields 1).
REQ-009 SHALL, in ONSPILL on hb_pkt_valid with hb_onspill=0: go OFFSPILL, increment spill_cnt, no hb_valid.
REQ-010 SHALL, in OFFSPILL on hb_pkt_valid with hb_onspill=0: increment hb_offspill_cnt; no hb_valid.
REQ-011 SHALL present spill_hbtag stable in the same cycle hb_valid is high (direct FIFO WE/DATA pairing).
REQ-012 SHALL saturate spill_hbtag at 2^20-1; further HBs still pulse hb_valid with saturated value and set hbtag_ovfl, cleared only by reset.
REQ-013 SHALL track last hb_ewtag of any HB; if a subsequent HB tag != last+1 (mod 2^48), increment ewtag_skip_cnt; first HB after reset is not checked.
REQ-014 SHALL register pref_pkt_valid to pref_valid with 1-cycle latency, independent of state; simultaneous HB and PREFETCH both produce pulses same cycle.
REQ-015 SHALL drive onspill high exactly while state is ONSPILL.
REQ-016 SHALL wrap all 32-bit diagnostic counters at 2^32.

Reset
REQ-017 SHALL on resetn_xcvrclk low, asynchronously clear all outputs and counters to 0, state to OFFSPILL, last-tag-valid flag to 0.
REQ-018 SHALL, on reset mid-spill, resume in OFFSPILL, so next on-spill HB produces start_spill and spill_hbtag=1.

Structure
REQ-019 SHALL take EVENT_TAG_BITS and SPILL_TAG_BITS from tracker_params.vh; state encodings stay local.
REQ-020 SHALL use sub-module ewtag_continuity_chk (last-tag register, compare, skip counter).

Verification
REQ-021 Reset, then 3 HBs onspill=1, tags 100..102 -> start_spill once, hb_valid x3, spill_hbtag 1,2,3, ewtag_skip_cnt=0.
REQ-022 Spill of 2 HBs, HB onspill=0, new spill HB -> spill_cnt=1, second start_spill, spill_hbtag=1.
REQ-023 Tags 10,11,13 onspill=1 -> ewtag_skip_cnt=1.
REQ-024 Null HB mid-spill between non-null HBs -> hb_null_valid once, spill_hbtag 1 then 2.
REQ-025 Preload spill_hbtag to 0xFFFFE, 3 HBs -> values 0xFFFFF,0xFFFFF,0xFFFFF, hbtag_ovfl=1.
REQ-026 Simultaneous hb_pkt_valid and pref_pkt_valid, then reset mid-spill -> both pulses next cycle; after reset, onspill=0 and next HB gives start_spill.

Source files
------------

// File: rtl/hb_spill_tag_gen_pkg.sv
// Shared widths for the HeartBeat spill tag generator.
//
// EVENT_TAG_BITS : width of the event window tag carried by each HeartBeat.
// SPILL_TAG_BITS : width of the local per-spill HeartBeat counter.
// DIAG_CNT_BITS  : width of the free-running diagnostic counters (wrap at 2^32).
package hb_spill_tag_gen_pkg;

    localparam int unsigned EVENT_TAG_BITS = 48;
    localparam int unsigned SPILL_TAG_BITS = 20;
    localparam int unsigned DIAG_CNT_BITS  = 32;

    typedef logic [DIAG_CNT_BITS-1:0] diag_cnt_t;

endpackage

// File: rtl/ewtag_continuity_chk.sv
// Event window tag continuity checker.
//
// Remembers the tag of the most recent HeartBeat and counts every later
// HeartBeat whose tag is not exactly the previous one plus one (modulo
// 2^TagBits). The first HeartBeat after reset only primes the register.
//
// Ports:
//   xcvrclk        in   clock
//   resetn_xcvrclk in   asynchronous active-low reset
//   tag_valid      in   HeartBeat decoded this cycle
//   tag            in   event window tag of that HeartBeat
//   skip_cnt       out  number of tag discontinuities seen, wraps
module ewtag_continuity_chk #(
    parameter int unsigned TagBits = 48,
    parameter int unsigned CntBits = 32
) (
    input  logic               xcvrclk,
    input  logic               resetn_xcvrclk,
    input  logic               tag_valid,
    input  logic [TagBits-1:0] tag,
    output logic [CntBits-1:0] skip_cnt
);

    logic [TagBits-1:0] last_tag_q;
    logic               last_valid_q;
    logic [TagBits-1:0] expected_tag;
    logic               skip;

    // Natural width truncation gives the modulo-2^TagBits wrap.
    assign expected_tag = last_tag_q + TagBits'(1);
    assign skip         = tag_valid && last_valid_q && (tag != expected_tag);

    always_ff @(posedge xcvrclk or negedge resetn_xcvrclk) begin
        if (!resetn_xcvrclk) begin
            last_tag_q   <= '0;
            last_valid_q <= 1'b0;
            skip_cnt     <= '0;
        end else if (tag_valid) begin
            last_tag_q   <= tag;
            last_valid_q <= 1'b1;
            if (skip) begin
                skip_cnt <= skip_cnt + CntBits'(1);
            end
        end
    end

endmodule

// File: rtl/hb_spill_tag_gen.sv
// HeartBeat spill tag generator.
//
// Tracks spill / inter-spill periods from decoded HeartBeat packets and
// produces a local per-spill HeartBeat number (spill_hbtag) that is valid in
// the same cycle as hb_valid, so the pair can drive a FIFO write directly.
// PREFETCH pulses are simply re-timed by one cycle.
//
// Ports:
//   xcvrclk, resetn_xcvrclk  clock and asynchronous active-low reset
//   hb_pkt_valid             decoded HeartBeat, 1-cycle pulse
//   hb_ewtag                 event window tag of the HeartBeat
//   hb_onspill               ONSPILL bit of the HeartBeat
//   hb_null                  HeartBeat carries no-data mode
//   pref_pkt_valid           decoded PREFETCH, 1-cycle pulse
//   hb_valid                 non-null on-spill HeartBeat pulse
//   hb_null_valid            null HeartBeat pulse
//   pref_valid               PREFETCH pulse
//   spill_hbtag              per-spill HeartBeat number, qualified by hb_valid
//   start_spill              first HeartBeat of a spill
//   onspill                  high while in a spill
//   spill_cnt                completed spills
//   ewtag_skip_cnt           event tag discontinuities
//   hb_offspill_cnt          HeartBeats seen outside a spill
//   hbtag_ovfl               sticky: spill_hbtag saturated and another HB came
module hb_spill_tag_gen
    import hb_spill_tag_gen_pkg::*;
#(
    parameter int unsigned EventTagBits = EVENT_TAG_BITS,
    parameter int unsigned SpillTagBits = SPILL_TAG_BITS
) (
    input  logic                     xcvrclk,
    input  logic                     resetn_xcvrclk,
    input  logic                     hb_pkt_valid,
    input  logic [EventTagBits-1:0]  hb_ewtag,
    input  logic                     hb_onspill,
    input  logic                     hb_null,
    input  logic                     pref_pkt_valid,
    output logic                     hb_valid,
    output logic                     hb_null_valid,
    output logic                     pref_valid,
    output logic [SpillTagBits-1:0]  spill_hbtag,
    output logic                     start_spill,
    output logic                     onspill,
    output logic [DIAG_CNT_BITS-1:0] spill_cnt,
    output logic [DIAG_CNT_BITS-1:0] ewtag_skip_cnt,
    output logic [DIAG_CNT_BITS-1:0] hb_offspill_cnt,
    output logic                     hbtag_ovfl
);

    typedef enum logic {
        StOffspill = 1'b0,
        StOnspill  = 1'b1
    } spill_state_e;

    localparam logic [SpillTagBits-1:0] TagMax = '1;
    localparam logic [SpillTagBits-1:0] TagOne = SpillTagBits'(1);

    spill_state_e state_q;

    assign onspill = (state_q == StOnspill);

    // Spill FSM with all pulse outputs and counters registered here.
    always_ff @(posedge xcvrclk or negedge resetn_xcvrclk) begin
        if (!resetn_xcvrclk) begin
            state_q         <= StOffspill;
            hb_valid        <= 1'b0;
            hb_null_valid   <= 1'b0;
            pref_valid      <= 1'b0;
            start_spill     <= 1'b0;
            spill_hbtag     <= '0;
            spill_cnt       <= '0;
            hb_offspill_cnt <= '0;
            hbtag_ovfl      <= 1'b0;
        end else begin
            hb_valid      <= 1'b0;
            hb_null_valid <= 1'b0;
            start_spill   <= 1'b0;
            pref_valid    <= pref_pkt_valid;

            if (hb_pkt_valid) begin
                hb_null_valid <= hb_null;
                unique case (state_q)
                    StOffspill: begin
                        if (hb_onspill) begin
                            state_q     <= StOnspill;
                            start_spill <= 1'b1;
                            hb_valid    <= !hb_null;
                            // A null first HB leaves the counter at 0 so the
                            // next data HB of the spill is numbered 1.
                            spill_hbtag <= hb_null ? '0 : TagOne;
                        end else begin
                            hb_offspill_cnt <= hb_offspill_cnt + DIAG_CNT_BITS'(1);
                        end
                    end
                    StOnspill: begin
                        if (!hb_onspill) begin
                            state_q   <= StOffspill;
                            spill_cnt <= spill_cnt + DIAG_CNT_BITS'(1);
                        end else if (!hb_null) begin
                            hb_valid <= 1'b1;
                            if (spill_hbtag == TagMax) begin
                                hbtag_ovfl <= 1'b1;
                            end else begin
                                spill_hbtag <= spill_hbtag + TagOne;
                            end
                        end
                    end
                    default: state_q <= StOffspill;
                endcase
            end
        end
    end

    ewtag_continuity_chk #(
        .TagBits (EventTagBits),
        .CntBits (DIAG_CNT_BITS)
    ) u_ewtag_chk (
        .xcvrclk        (xcvrclk),
        .resetn_xcvrclk (resetn_xcvrclk),
        .tag_valid      (hb_pkt_valid),
        .tag            (hb_ewtag),
        .skip_cnt       (ewtag_skip_cnt)
    );

endmodule

// File: tb/tb_hb_spill_tag_gen.sv
// Scoreboard bench for hb_spill_tag_gen. Two instances share the stimulus:
// one at the default 20-bit spill tag width and one at 4 bits so that tag
// saturation and the overflow flag are reached within a short run.
module tb_hb_spill_tag_gen;

    localparam int unsigned SmallBits = 4;
    localparam int unsigned LargeMax  = (1 << 20) - 1;
    localparam int unsigned SmallMax  = (1 << SmallBits) - 1;

    logic        xcvrclk = 1'b0;
    logic        resetn_xcvrclk = 1'b0;
    logic        hb_pkt_valid = 1'b0;
    logic [47:0] hb_ewtag = '0;
    logic        hb_onspill = 1'b0;
    logic        hb_null = 1'b0;
    logic        pref_pkt_valid = 1'b0;

    logic        l_hb_valid, l_hb_null_valid, l_pref_valid, l_start_spill, l_onspill, l_ovfl;
    logic [19:0] l_tag;
    logic [31:0] l_spill_cnt, l_skip_cnt, l_off_cnt;
    logic        s_hb_valid, s_hb_null_valid, s_pref_valid, s_start_spill, s_onspill, s_ovfl;
    logic [SmallBits-1:0] s_tag;
    logic [31:0] s_spill_cnt, s_skip_cnt, s_off_cnt;

    always #5 xcvrclk = ~xcvrclk;

    hb_spill_tag_gen dut_l (
        .xcvrclk         (xcvrclk),
        .resetn_xcvrclk  (resetn_xcvrclk),
        .hb_pkt_valid    (hb_pkt_valid),
        .hb_ewtag        (hb_ewtag),
        .hb_onspill      (hb_onspill),
        .hb_null         (hb_null),
        .pref_pkt_valid  (pref_pkt_valid),
        .hb_valid        (l_hb_valid),
        .hb_null_valid   (l_hb_null_valid),
        .pref_valid      (l_pref_valid),
        .spill_hbtag     (l_tag),
        .start_spill     (l_start_spill),
        .onspill         (l_onspill),
        .spill_cnt       (l_spill_cnt),
        .ewtag_skip_cnt  (l_skip_cnt),
        .hb_offspill_cnt (l_off_cnt),
        .hbtag_ovfl      (l_ovfl)
    );

    hb_spill_tag_gen #(
        .SpillTagBits (SmallBits)
    ) dut_s (
        .xcvrclk         (xcvrclk),
        .resetn_xcvrclk  (resetn_xcvrclk),
        .hb_pkt_valid    (hb_pkt_valid),
        .hb_ewtag        (hb_ewtag),
        .hb_onspill      (hb_onspill),
        .hb_null         (hb_null),
        .pref_pkt_valid  (pref_pkt_valid),
        .hb_valid        (s_hb_valid),
        .hb_null_valid   (s_hb_null_valid),
        .pref_valid      (s_pref_valid),
        .spill_hbtag     (s_tag),
        .start_spill     (s_start_spill),
        .onspill         (s_onspill),
        .spill_cnt       (s_spill_cnt),
        .ewtag_skip_cnt  (s_skip_cnt),
        .hb_offspill_cnt (s_off_cnt),
        .hbtag_ovfl      (s_ovfl)
    );

    // Expected response of one input cycle that produces at least one pulse.
    typedef struct {
        bit          hbv, hbn, start, pref, ons, ovf_l, ovf_s;
        int unsigned tag_l, tag_s;
        bit [31:0]   spills, skips, offs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: the spill tag is just the number of data HBs seen in
    // the current spill, clipped to the counter's maximum.
    bit          m_in_spill;
    int unsigned m_data_hbs;
    bit          m_has_last;
    logic [47:0] m_last_tag;
    bit [31:0]   m_spills, m_skips, m_offs;
    bit          m_ovf_l, m_ovf_s;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_in_spill = 0; m_data_hbs = 0; m_has_last = 0; m_last_tag = '0;
        m_spills = 0; m_skips = 0; m_offs = 0; m_ovf_l = 0; m_ovf_s = 0;
    endtask

    task automatic model_issue(input bit hb, input logic [47:0] tag, input bit ons,
                               input bit nul, input bit pref);
        exp_t e;
        logic [47:0] want;
        e = '{default: 0};
        e.pref = pref;
        if (hb) begin
            want = m_last_tag + 48'd1;
            if (m_has_last && tag != want) m_skips++;
            m_last_tag = tag;
            m_has_last = 1;
            e.hbn = nul;
            if (ons) begin
                if (!m_in_spill) begin
                    m_in_spill = 1;
                    m_data_hbs = 0;
                    e.start = 1;
                end
                if (!nul) begin
                    m_data_hbs++;
                    e.hbv = 1;
                    if (m_data_hbs > LargeMax) m_ovf_l = 1;
                    if (m_data_hbs > SmallMax) m_ovf_s = 1;
                end
            end else if (m_in_spill) begin
                m_in_spill = 0;
                m_spills++;
            end else begin
                m_offs++;
            end
        end
        e.tag_l  = (m_data_hbs > LargeMax) ? LargeMax : m_data_hbs;
        e.tag_s  = (m_data_hbs > SmallMax) ? SmallMax : m_data_hbs;
        e.ons    = m_in_spill;
        e.ovf_l  = m_ovf_l;
        e.ovf_s  = m_ovf_s;
        e.spills = m_spills;
        e.skips  = m_skips;
        e.offs   = m_offs;
        if (e.hbv || e.hbn || e.start || e.pref) q.push_back(e);
    endtask

    task automatic step(input bit hb, input logic [47:0] tag, input bit ons,
                        input bit nul, input bit pref);
        @(posedge xcvrclk);
        #1;
        hb_pkt_valid   = hb;
        hb_ewtag       = tag;
        hb_onspill     = ons;
        hb_null        = nul;
        pref_pkt_valid = pref;
        model_issue(hb, tag, ons, nul, pref);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    task automatic hb(input logic [47:0] tag, input bit ons, input bit nul);
        step(1, tag, ons, nul, 0);
    endtask

    // Assert reset away from the monitor's sampling instant and check that
    // every output of both instances is cleared.
    task automatic do_reset();
        @(posedge xcvrclk);
        #1;
        hb_pkt_valid = 0; pref_pkt_valid = 0; hb_onspill = 0; hb_null = 0;
        @(negedge xcvrclk);
        #2;
        resetn_xcvrclk = 1'b0;
        #1;
        chk("rst_pending_queue", q.size(), 0);
        q.delete();
        model_reset();
        chk("rst_l_hb_valid", l_hb_valid, 0);
        chk("rst_l_hb_null_valid", l_hb_null_valid, 0);
        chk("rst_l_pref_valid", l_pref_valid, 0);
        chk("rst_l_spill_hbtag", l_tag, 0);
        chk("rst_l_start_spill", l_start_spill, 0);
        chk("rst_l_onspill", l_onspill, 0);
        chk("rst_l_spill_cnt", l_spill_cnt, 0);
        chk("rst_l_skip_cnt", l_skip_cnt, 0);
        chk("rst_l_offspill_cnt", l_off_cnt, 0);
        chk("rst_l_ovfl", l_ovfl, 0);
        chk("rst_s_spill_hbtag", s_tag, 0);
        chk("rst_s_onspill", s_onspill, 0);
        chk("rst_s_ovfl", s_ovfl, 0);
        repeat (2) @(posedge xcvrclk);
        #3;
        resetn_xcvrclk = 1'b1;
    endtask

    // Monitor: pops one expectation whenever either instance presents a pulse.
    always @(negedge xcvrclk) begin
        if (resetn_xcvrclk && (l_hb_valid || l_hb_null_valid || l_pref_valid || l_start_spill ||
                               s_hb_valid || s_hb_null_valid || s_pref_valid || s_start_spill)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("l_hb_valid", l_hb_valid, e.hbv);
                chk("l_hb_null_valid", l_hb_null_valid, e.hbn);
                chk("l_pref_valid", l_pref_valid, e.pref);
                chk("l_start_spill", l_start_spill, e.start);
                chk("l_onspill", l_onspill, e.ons);
                if (e.hbv) chk("l_spill_hbtag", l_tag, e.tag_l);
                chk("l_hbtag_ovfl", l_ovfl, e.ovf_l);
                chk("l_spill_cnt", l_spill_cnt, e.spills);
                chk("l_skip_cnt", l_skip_cnt, e.skips);
                chk("l_offspill_cnt", l_off_cnt, e.offs);
                chk("s_hb_valid", s_hb_valid, e.hbv);
                chk("s_start_spill", s_start_spill, e.start);
                chk("s_onspill", s_onspill, e.ons);
                if (e.hbv) chk("s_spill_hbtag", s_tag, e.tag_s);
                chk("s_hbtag_ovfl", s_ovfl, e.ovf_s);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1, "timeout");
    end

    initial begin
        bit          gen_ons;
        logic [47:0] cur_tag;
        model_reset();
        do_reset();

        // Three data HBs of a fresh spill, contiguous tags.
        hb(100, 1, 0); hb(101, 1, 0); hb(102, 1, 0); idle();
        // End spill, short spill of two, end again, new spill restarts at 1.
        hb(103, 0, 0); hb(104, 1, 0); hb(105, 1, 0); hb(106, 0, 0); hb(107, 1, 0); idle();
        // Tag discontinuity 11 -> 13.
        hb(108, 0, 0); hb(10, 1, 0); hb(11, 1, 0); hb(13, 1, 0); idle();
        // Null HB between two data HBs.
        hb(14, 0, 0); hb(15, 1, 0); hb(16, 1, 1); hb(17, 1, 0); idle();
        // Off-spill HBs, then a spill whose first HB is null.
        hb(18, 0, 0); hb(19, 0, 0); hb(20, 0, 1); hb(21, 1, 1); hb(22, 1, 0); idle();
        // Long spill drives the narrow instance into saturation.
        for (int i = 0; i < SmallMax + 3; i++) hb(48'(23 + i), 1, 0);
        idle();
        // HB and PREFETCH together, then reset mid-spill.
        step(1, 48'(23 + SmallMax + 3), 1, 0, 1);
        do_reset();
        chk("post_reset_onspill", l_onspill, 0);
        hb(500, 1, 0); idle();

        // Randomized traffic with long spills and occasional tag jumps.
        gen_ons = 0;
        cur_tag = 48'hFFFF_FFFF_FFF0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) gen_ons = ~gen_ons;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 9) == 0) cur_tag = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                else cur_tag = cur_tag + 48'd1;
                step(1, cur_tag, gen_ons, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
            end else begin
                step(0, '0, 0, 0, ($urandom_range(0, 2) == 0));
            end
        end
        repeat (3) idle();
        @(negedge xcvrclk);
        #1;
        chk("queue_drained", q.size(), 0);
        chk("final_spill_cnt", l_spill_cnt, m_spills);
        chk("final_skip_cnt", l_skip_cnt, m_skips);
        chk("final_offspill_cnt", l_off_cnt, m_offs);
        chk("final_onspill", l_onspill, m_in_spill);
        chk("final_l_ovfl", l_ovfl, m_ovf_l);
        chk("final_s_ovfl", s_ovfl, m_ovf_s);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
